// File: rtl/bus_definitions.sv
// Shared bus definitions: word/depth parameters and the one-hot FIFO operation
// encoding used by bus_fifo.
package bus_definitions;

    localparam int ws         = 4;
    localparam int depth      = 8;
    localparam int as         = $clog2(depth);
    localparam int FIFO_CNT_W = as + 1;

    typedef enum logic [3:0] {
        IDLE          = 4'b0001,
        REMOVE        = 4'b0010,
        INSERT        = 4'b0100,
        INSERT_REMOVE = 4'b1000
    } fifo_fsm_states_t;

    // Bit positions of each one-hot state, for unique case decoding.
    typedef enum logic [1:0] {
        IDLE_BIT          = 2'd0,
        REMOVE_BIT        = 2'd1,
        INSERT_BIT        = 2'd2,
        INSERT_REMOVE_BIT = 2'd3
    } fifo_state_bit_t;

endpackage

// File: rtl/bus_fifo_regfile.sv
// depth x ws storage for bus_fifo: one synchronous write port and one
// combinational read port; contents cleared by reset.
module bus_fifo_regfile #(
    parameter int ws    = bus_definitions::ws,
    parameter int depth = bus_definitions::depth,
    parameter int as    = $clog2(depth)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [as-1:0] waddr_i,
    input  logic [ws-1:0] wdata_i,
    input  logic [as-1:0] raddr_i,
    output logic [ws-1:0] rdata_o
);

    logic [ws-1:0] mem_q [depth];

    // NOTE: the array is reset on purpose so the FWFT head reads 0 after reset;
    // this forces flops instead of a RAM macro, acceptable at this size.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < depth; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/bus_fifo.sv
// First-word-fall-through word FIFO between a producer agent and the shared bus,
// sequenced by the one-hot idle/remove/insert/insert_remove operation machine.
module bus_fifo #(
    parameter int   ws    = bus_definitions::ws,
    parameter int   depth = bus_definitions::depth,
    localparam int  as    = $clog2(depth)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic [ws-1:0] D_in,
    input  logic          pop,
    output logic [ws-1:0] D_out,
    output logic          pndng,
    output logic          full,
    output logic [as:0]   count,
    output logic [3:0]    state,
    output logic          overflow,
    output logic          underflow
);

    import bus_definitions::fifo_fsm_states_t;
    import bus_definitions::IDLE;
    import bus_definitions::REMOVE;
    import bus_definitions::INSERT;
    import bus_definitions::INSERT_REMOVE;
    import bus_definitions::IDLE_BIT;
    import bus_definitions::REMOVE_BIT;
    import bus_definitions::INSERT_BIT;
    import bus_definitions::INSERT_REMOVE_BIT;

    localparam int            CNT_W   = as + 1;
    localparam logic [as-1:0] PTR_ONE = 1;
    localparam logic [as:0]   CNT_ONE = 1;

    logic [as-1:0]    wr_ptr_q, rd_ptr_q;
    logic [as:0]      count_q;
    fifo_fsm_states_t state_q, op_d;
    logic             overflow_q, underflow_q;
    logic             push_ok, pop_ok;

    // Flags come from the registered count only, so they never glitch.
    assign full  = (count_q == CNT_W'(depth));
    assign pndng = (count_q != '0);

    // A pop frees the slot a simultaneous push takes, so push is legal when full.
    assign pop_ok  = pop & pndng;
    assign push_ok = push & (~full | pop_ok);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        op_d = IDLE;
        case ({push_ok, pop_ok})
            2'b01:   op_d = REMOVE;
            2'b10:   op_d = INSERT;
            2'b11:   op_d = INSERT_REMOVE;
            default: op_d = IDLE;
        endcase
    end

    // NOTE: all state below uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            state_q     <= IDLE;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            state_q <= op_d;
            unique case (1'b1)
                op_d[IDLE_BIT]: begin
                end
                op_d[REMOVE_BIT]: begin
                    rd_ptr_q <= rd_ptr_q + PTR_ONE;
                    count_q  <= count_q - CNT_ONE;
                end
                op_d[INSERT_BIT]: begin
                    wr_ptr_q <= wr_ptr_q + PTR_ONE;
                    count_q  <= count_q + CNT_ONE;
                end
                op_d[INSERT_REMOVE_BIT]: begin
                    wr_ptr_q <= wr_ptr_q + PTR_ONE;
                    rd_ptr_q <= rd_ptr_q + PTR_ONE;
                end
                default: begin
                end
            endcase
            if (push && !push_ok) begin
                overflow_q <= 1'b1;
            end
            if (pop && !pndng) begin
                underflow_q <= 1'b1;
            end
        end
    end

    bus_fifo_regfile #(
        .ws    (ws),
        .depth (depth),
        .as    (as)
    ) u_regfile (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (push_ok),
        .waddr_i (wr_ptr_q),
        .wdata_i (D_in),
        .raddr_i (rd_ptr_q),
        .rdata_o (D_out)
    );

    assign count     = count_q;
    assign state     = state_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_bus_fifo.sv
// Directed plus random bench for bus_fifo against a queue-based reference model.
module tb_bus_fifo;

    localparam int WS    = 4;
    localparam int DEPTH = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          push;
    logic [WS-1:0] D_in;
    logic          pop;
    logic [WS-1:0] D_out;
    logic          pndng;
    logic          full;
    logic [3:0]    count;
    logic [3:0]    state;
    logic          overflow;
    logic          underflow;

    int errors = 0;
    int checks = 0;

    // Reference model: contents as a queue, sticky flags, last operation.
    logic [WS-1:0] q [$];
    bit            m_ov;
    bit            m_un;
    logic [3:0]    m_state;

    always #5 clk = ~clk;

    bus_fifo dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .D_in      (D_in),
        .pop       (pop),
        .D_out     (D_out),
        .pndng     (pndng),
        .full      (full),
        .count     (count),
        .state     (state),
        .overflow  (overflow),
        .underflow (underflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_ov    = 1'b0;
        m_un    = 1'b0;
        m_state = 4'b0001;
    endtask

    task automatic model_step(input bit p, input bit o, input logic [WS-1:0] d);
        bit pop_ok;
        bit push_ok;
        pop_ok  = o && (q.size() > 0);
        push_ok = p && ((q.size() < DEPTH) || pop_ok);
        if (o && q.size() == 0) m_un = 1'b1;
        if (p && !push_ok) m_ov = 1'b1;
        if (pop_ok) q.delete(0);
        if (push_ok) q.push_back(d);
        m_state = push_ok ? (pop_ok ? 4'b1000 : 4'b0100) : (pop_ok ? 4'b0010 : 4'b0001);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".count"}, 32'(count), 32'(q.size()));
        check({tag, ".pndng"}, 32'(pndng), 32'(q.size() > 0));
        check({tag, ".full"}, 32'(full), 32'(q.size() == DEPTH));
        check({tag, ".state"}, 32'(state), 32'(m_state));
        check({tag, ".ovf"}, 32'(overflow), 32'(m_ov));
        check({tag, ".unf"}, 32'(underflow), 32'(m_un));
        if (q.size() > 0) check({tag, ".dout"}, 32'(D_out), 32'(q[0]));
    endtask

    // Apply one operation for one clock edge, then compare just after the edge.
    task automatic do_op(input string tag, input bit p, input bit o, input logic [WS-1:0] d);
        push = p;
        pop  = o;
        D_in = d;
        model_step(p, o, d);
        @(posedge clk);
        #1;
        push = 1'b0;
        pop  = 1'b0;
        check_all(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        push  = 1'b0;
        pop   = 1'b0;
        D_in  = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all("reset");
        check("reset.dout0", 32'(D_out), 32'h0);

        for (int i = 1; i <= 8; i++) do_op("fill", 1'b1, 1'b0, WS'(i));
        check("fill.full", 32'(full), 32'h1);
        check("fill.count8", 32'(count), 32'h8);

        do_op("overflow", 1'b1, 1'b0, 4'hF);
        check("overflow.sticky", 32'(overflow), 32'h1);
        check("overflow.head", 32'(D_out), 32'h1);

        do_op("full_push_pop", 1'b1, 1'b1, 4'hA);
        check("full_push_pop.state", 32'(state), 32'h8);
        check("full_push_pop.head", 32'(D_out), 32'h2);

        for (int i = 0; i < 8; i++) begin
            if (i == 7) check("drain.last_is_A", 32'(D_out), 32'hA);
            do_op("drain", 1'b0, 1'b1, '0);
            check("drain.state_remove", 32'(state), 32'h2);
        end
        check("drain.empty", 32'(pndng), 32'h0);

        do_op("empty_push_pop", 1'b1, 1'b1, 4'h5);
        check("empty_push_pop.state", 32'(state), 32'h4);
        check("empty_push_pop.unf", 32'(underflow), 32'h1);
        check("empty_push_pop.dout", 32'(D_out), 32'h5);

        for (int i = 0; i < 40; i++) begin
            do_op("random", $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 55,
                  WS'($urandom_range(0, 15)));
        end

        do_op("pre_reset", 1'b1, 1'b0, 4'h3);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all("async_reset");
        check("async_reset.pndng", 32'(pndng), 32'h0);
        check("async_reset.dout0", 32'(D_out), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op("after_reset", 1'b1, 1'b0, 4'h9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
